// File: rtl/writeback_commit_queue.sv
// In-order commit queue feeding the register-file write port from the ALU and load paths.
// Reports queued destinations so decode can hold off reads of uncommitted registers.
module writeback_commit_queue #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEPTH         = 4
) (
  input  logic                     iClk,
  input  logic                     iRstN,
  input  logic                     iAluValid,
  input  logic [ADDRESS_WIDTH-1:0] iAluRd,
  input  logic [DATA_WIDTH-1:0]    iAluData,
  output logic                     oAluReady,
  input  logic                     iLoadValid,
  input  logic [ADDRESS_WIDTH-1:0] iLoadRd,
  input  logic [DATA_WIDTH-1:0]    iLoadData,
  output logic                     oLoadReady,
  output logic                     oWriteEn,
  output logic [ADDRESS_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0]    oWriteData,
  input  logic [ADDRESS_WIDTH-1:0] iCheckAddr1,
  input  logic [ADDRESS_WIDTH-1:0] iCheckAddr2,
  output logic                     oPending1,
  output logic                     oPending2,
  output logic [$clog2(DEPTH):0]   oCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]         count_q, count_d;
  logic [PTR_W-1:0]         rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]         wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]         loadSlot;
  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [ADDRESS_WIDTH-1:0] rd_q   [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];

  logic aluAccept;
  logic aluPush;
  logic loadPush;
  logic pop;

  // Readiness looks only at the registered count; the pop happening this cycle is not credited.
  assign oAluReady  = count_q < CNT_W'(DEPTH);
  assign aluAccept  = iAluValid & oAluReady;
  assign oLoadReady = (count_q + CNT_W'(aluAccept)) < CNT_W'(DEPTH);

  // x0 writes finish their handshake but never occupy a slot.
  assign aluPush  = aluAccept & (iAluRd != '0);
  assign loadPush = iLoadValid & oLoadReady & (iLoadRd != '0);
  assign pop      = (count_q != '0);

  assign loadSlot = wrPtr_q + PTR_W'(aluPush);

  always_comb begin
    count_d = count_q + CNT_W'(aluPush) + CNT_W'(loadPush) - CNT_W'(pop);
    rdPtr_d = rdPtr_q + PTR_W'(pop);
    wrPtr_d = wrPtr_q + PTR_W'(aluPush) + PTR_W'(loadPush);
    valid_d = valid_q;
    if (pop)      valid_d[rdPtr_q]  = 1'b0;
    if (aluPush)  valid_d[wrPtr_q]  = 1'b1;
    if (loadPush) valid_d[loadSlot] = 1'b1;
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      count_q <= '0;
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      valid_q <= valid_d;
      if (aluPush) begin
        rd_q[wrPtr_q]   <= iAluRd;
        data_q[wrPtr_q] <= iAluData;
      end
      if (loadPush) begin
        rd_q[loadSlot]   <= iLoadRd;
        data_q[loadSlot] <= iLoadData;
      end
    end
  end

  assign oWriteEn      = pop;
  assign oWriteAddress = pop ? rd_q[rdPtr_q] : '0;
  assign oWriteData    = pop ? data_q[rdPtr_q] : '0;
  assign oCount        = count_q;

  // The head stays visible as pending while it is being written this cycle.
  always_comb begin
    oPending1 = 1'b0;
    oPending2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (rd_q[i] == iCheckAddr1) && (iCheckAddr1 != '0)) oPending1 = 1'b1;
      if (valid_q[i] && (rd_q[i] == iCheckAddr2) && (iCheckAddr2 != '0)) oPending2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_writeback_commit_queue.sv
// Scoreboard bench for writeback_commit_queue: directed scenarios followed by random traffic,
// with a negedge monitor comparing commits, count, readiness and pending flags against a queue model.
module tb_writeback_commit_queue;

  logic        iClk;
  logic        iRstN;
  logic        iAluValid;
  logic [4:0]  iAluRd;
  logic [31:0] iAluData;
  logic        oAluReady;
  logic        iLoadValid;
  logic [4:0]  iLoadRd;
  logic [31:0] iLoadData;
  logic        oLoadReady;
  logic        oWriteEn;
  logic [4:0]  oWriteAddress;
  logic [31:0] oWriteData;
  logic [4:0]  iCheckAddr1;
  logic [4:0]  iCheckAddr2;
  logic        oPending1;
  logic        oPending2;
  logic [2:0]  oCount;

  int checks = 0;
  int failures = 0;

  // Each expected commit is {rd, data}, oldest at the front.
  logic [36:0] expQ [$];

  writeback_commit_queue #(.ADDRESS_WIDTH(5), .DATA_WIDTH(32), .DEPTH(4)) dut (
    .iClk(iClk), .iRstN(iRstN),
    .iAluValid(iAluValid), .iAluRd(iAluRd), .iAluData(iAluData), .oAluReady(oAluReady),
    .iLoadValid(iLoadValid), .iLoadRd(iLoadRd), .iLoadData(iLoadData), .oLoadReady(oLoadReady),
    .oWriteEn(oWriteEn), .oWriteAddress(oWriteAddress), .oWriteData(oWriteData),
    .iCheckAddr1(iCheckAddr1), .iCheckAddr2(iCheckAddr2),
    .oPending1(oPending1), .oPending2(oPending2), .oCount(oCount)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic logic modelPending(input logic [4:0] addr);
    if (addr == 5'd0) return 1'b0;
    foreach (expQ[i]) if (expQ[i][36:32] == addr) return 1'b1;
    return 1'b0;
  endfunction

  // Drive one cycle of inputs shortly after a posedge, then record what the queue accepts.
  task automatic applyStimulus(input logic aV, input logic [4:0] aRd, input logic [31:0] aD,
                               input logic lV, input logic [4:0] lRd, input logic [31:0] lD,
                               input logic [4:0] c1, input logic [4:0] c2);
    int  occ;
    logic aAcc, lAcc;
    iAluValid = aV; iAluRd = aRd; iAluData = aD;
    iLoadValid = lV; iLoadRd = lRd; iLoadData = lD;
    iCheckAddr1 = c1; iCheckAddr2 = c2;
    occ  = expQ.size();
    aAcc = aV && (occ < 4);
    lAcc = lV && ((occ + (aAcc ? 1 : 0)) < 4);
    @(posedge iClk);
    if (aAcc && aRd != 5'd0) expQ.push_back({aRd, aD});
    if (lAcc && lRd != 5'd0) expQ.push_back({lRd, lD});
    #2;
  endtask

  task automatic idle(input int n, input logic [4:0] c1);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, c1, 0);
  endtask

  // Monitor: before the head pops, compare everything the DUT presents against the model.
  always @(negedge iClk) begin
    if (iRstN) begin
      checkOutput("count", 64'(oCount), 64'(expQ.size()));
      checkOutput("writeEn", 64'(oWriteEn), 64'(expQ.size() != 0));
      checkOutput("aluReady", 64'(oAluReady), 64'(expQ.size() < 4));
      checkOutput("loadReady", 64'(oLoadReady),
                  64'((expQ.size() + ((iAluValid && expQ.size() < 4) ? 1 : 0)) < 4));
      checkOutput("pending1", 64'(oPending1), 64'(modelPending(iCheckAddr1)));
      checkOutput("pending2", 64'(oPending2), 64'(modelPending(iCheckAddr2)));
      if (oWriteEn) begin
        if (expQ.size() == 0) begin
          checkOutput("writeWhenEmpty", 64'(oWriteEn), 64'd0);
        end else begin
          checkOutput("writeAddress", 64'(oWriteAddress), 64'(expQ[0][36:32]));
          checkOutput("writeData", 64'(oWriteData), 64'(expQ[0][31:0]));
          void'(expQ.pop_front());
        end
      end else begin
        checkOutput("idleAddress", 64'(oWriteAddress), 64'd0);
        checkOutput("idleData", 64'(oWriteData), 64'd0);
      end
    end
  end

  initial begin
    iRstN = 1'b0;
    iAluValid = 0; iAluRd = 0; iAluData = 0;
    iLoadValid = 0; iLoadRd = 0; iLoadData = 0;
    iCheckAddr1 = 5'd7; iCheckAddr2 = 5'd0;
    #1;
    checkOutput("resetWriteEn", 64'(oWriteEn), 64'd0);
    checkOutput("resetCount", 64'(oCount), 64'd0);
    checkOutput("resetPending1", 64'(oPending1), 64'd0);
    checkOutput("resetAluReady", 64'(oAluReady), 64'd1);
    checkOutput("resetLoadReady", 64'(oLoadReady), 64'd1);
    @(posedge iClk); #2;
    @(posedge iClk); #2;
    iRstN = 1'b1;
    idle(2, 0);

    applyStimulus(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5'd5, 0);
    idle(2, 5'd5);

    applyStimulus(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 5'd4, 5'd3);
    idle(3, 5'd4);

    applyStimulus(1, 5'd0, 32'h55, 1, 5'd0, 32'h66, 0, 0);
    idle(2, 0);

    for (int i = 0; i < 5; i++)
      applyStimulus(1, 5'(i + 1), $urandom, 1, 5'(i + 10), $urandom, 5'(i + 10), 5'(i + 1));
    idle(4, 0);

    // Build three queued entries, then yank reset asynchronously mid-cycle.
    applyStimulus(1, 5'd6, 32'hA1, 1, 5'd7, 32'hA2, 5'd7, 0);
    applyStimulus(1, 5'd8, 32'hA3, 1, 5'd9, 32'hA4, 5'd9, 0);
    checkOutput("preResetCount", 64'(expQ.size()), 64'd3);
    iAluValid = 0; iLoadValid = 0;
    iRstN = 1'b0;
    #1;
    checkOutput("asyncResetWriteEn", 64'(oWriteEn), 64'd0);
    checkOutput("asyncResetCount", 64'(oCount), 64'd0);
    checkOutput("asyncResetPending", 64'(oPending1), 64'd0);
    expQ.delete();
    @(posedge iClk); #2;
    iRstN = 1'b1;
    idle(3, 5'd9);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 2) != 0, 5'($urandom_range(0, 31)), $urandom,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    idle(6, 0);
    checkOutput("drained", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
